// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C master arbiter.
package i2c_arb_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2,
    StResp     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module i2c_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] win,
  output logic            any
);

  int unsigned idx;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!any && req[idx[IdxW-1:0]]) begin
        any = 1'b1;
        win = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master engine among NREQ requesters.
// Optional watchdog on the transfer is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter import i2c_arb_pkg::*; #(
  parameter int unsigned NREQ = 4
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [NREQ*I2C_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]      rdata,
  output logic                       err,
  input  logic                       mst_ready,
  output logic                       mst_enable,
  output logic [I2C_ADDR_W-1:0]      mst_addr,
  output logic                       mst_rw,
  output logic [I2C_DATA_W-1:0]      mst_wdata,
  input  logic                       mst_done,
  input  logic [I2C_DATA_W-1:0]      mst_rdata,
  input  logic                       mst_nack,
  output logic                       mst_abort
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  enable_q, enable_d;
  logic [I2C_ADDR_W-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [I2C_DATA_W-1:0] wdata_q, wdata_d;

  logic [IdxW-1:0]       pick_win;
  logic                  pick_any;
  logic [NREQ-1:0]       pick_oh;
  logic [NREQ-1:0]       win_oh;
  logic [I2C_ADDR_W-1:0] sel_addr;
  logic                  sel_rw;
  logic [I2C_DATA_W-1:0] sel_wdata;

  i2c_rr_pick #(
    .NREQ(NREQ),
    .IdxW(IdxW)
  ) u_pick (
    .req(req),
    .ptr(ptr_q),
    .win(pick_win),
    .any(pick_any)
  );

  // Decode picker/latched winner to one-hot and mux the candidate command.
  always_comb begin
    pick_oh   = '0;
    win_oh    = '0;
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pick_oh[i] = (pick_win == IdxW'(i));
      win_oh[i]  = (win_q == IdxW'(i));
      if (pick_win == IdxW'(i)) begin
        sel_addr  = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    enable_d = 1'b0;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (pick_any && mst_ready) begin
          win_d    = pick_win;
          addr_d   = sel_addr;
          rw_d     = sel_rw;
          wdata_d  = sel_wdata;
          gnt_d    = pick_oh;
          enable_d = 1'b1;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWaitDone;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWaitDone: begin
        if (mst_done) begin
          rdata_d = mst_rdata;
          err_d   = mst_nack;
          done_d  = win_oh;
          state_d = StResp;
`ifdef I2C_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          // Watchdog expired: abort the master and report an error.
          abort_d = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = win_oh;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      StResp: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IdxW'(NREQ - 1)) ? '0 : win_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      enable_q <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      enable_q <= enable_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Watchdog counter and abort strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign mst_abort = abort_q;
`else
  assign mst_abort = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign mst_enable = enable_q;
  assign mst_addr   = addr_q;
  assign mst_rw     = rw_q;
  assign mst_wdata  = wdata_q;

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master engine among `NREQ` on-chip requesters. It latches the winning requester's command (7-bit slave address, R/W, write byte), launches a single byte transfer on the master, and waits for completion. It then returns read data and ACK status to the winner. It sits between the system's command sources and the I2C master that drives the bus shared by the slave controllers at 0x20 and 0x2B.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYC`, 16'd50000, watchdog limit in `clk` cycles (used only with `I2C_ARB_TIMEOUT_EN`)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req`  in  NREQ  per-requester request level
- `req_addr`  in  NREQ*7  packed slave addresses; requester i at [7i+6:7i]
- `req_rw`  in  NREQ  1 = read, 0 = write
- `req_wdata`  in  NREQ*8  packed write bytes; requester i at [8i+7:8i]
- `gnt`  out  NREQ  one-hot grant
- `done`  out  NREQ  one-cycle completion pulse to the winner
- `rdata`  out  8  read byte, valid during `done`
- `err`  out  1  NACK (or timeout) flag, valid during `done`
- `mst_ready`  in  1  master idle and able to accept a command
- `mst_enable`  out  1  one-cycle launch strobe
- `mst_addr`  out  7  latched address
- `mst_rw`  out  1  latched R/W
- `mst_wdata`  out  8  latched write byte
- `mst_done`  in  1  one-cycle transfer-complete pulse
- `mst_rdata`  in  8  master read byte, valid with `mst_done`
- `mst_nack`  in  1  slave NACKed, valid with `mst_done`
- `mst_abort`  out  1  one-cycle abort request (timeout build only; tied 0 otherwise)

## Operation
- FSM states: IDLE, LAUNCH, WAIT_DONE, RESP.
- IDLE: when `|req && mst_ready`, pick a winner by round robin starting at `ptr`. Latch the winner index and its addr/rw/wdata, then go to LAUNCH. If `mst_ready` is low, stay in IDLE.
- LAUNCH: `mst_enable`=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: on `mst_done`, capture `mst_rdata` into `rdata` and `mst_nack` into `err`, then go to RESP.
- RESP: `done[win]`=1 for one cycle, `ptr` = win+1 (mod NREQ), then go to IDLE.
- `gnt[win]` is high from LAUNCH through RESP inclusive, and low in IDLE.
- Command fields are latched at selection. Requester changes after that point are ignored, and dropping `req` mid-transaction does not cancel it.
- A requester that still holds `req` after `done` is treated as a new request, and lower-priority holders are served first.
- `mst_done` arriving outside WAIT_DONE is ignored.
- `rdata` and `err` hold their value until the next RESP.

## Timing
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `done`=0, `rdata`=0, `err`=0, `mst_enable`=0, `mst_addr`=0, `mst_rw`=0, `mst_wdata`=0, `mst_abort`=0.
- All outputs are registered.
- Latency: `req` sampled at edge N gives `gnt` and `mst_enable` at N+1, and WAIT_DONE from N+2.
- `mst_done` sampled at edge M gives `done` at M+1. The next grant can appear at M+3 at the earliest.
- Reset asserted mid-transaction: all outputs clear immediately and no `done` is issued. The master engine resets independently.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering WAIT_DONE and increments each cycle.
  - When it reaches `TIMEOUT_CYC-1` without `mst_done`, assert `mst_abort` for one cycle, set `err`=1 and `rdata`=0, and go to RESP.
  - If `mst_done` arrives on the terminal cycle, `mst_done` wins and there is no abort.
- Not defined: no counter exists, WAIT_DONE waits indefinitely, and `mst_abort` is tied 0.

## Structure
- Package `i2c_arb_pkg` holds the state encoding (IDLE=0, LAUNCH=1, WAIT_DONE=2, RESP=3) and the widths `I2C_ADDR_W`=7 and `I2C_DATA_W`=8.
- Sub-module `i2c_rr_pick` is a combinational round-robin picker. Inputs: `req`, `ptr`. Outputs: winner index and `any`.

## Test plan
- Single write: req[0], addr 0x20, rw 0, wdata 0xA5. Expect `mst_enable` one cycle with addr 0x20 / 0xA5; after `mst_done` (nack 0), expect `done[0]` one cycle with `err`=0.
- Read: req[2], addr 0x2B, rw 1; master returns 0x3C. Expect `rdata`=0x3C and `done[2]` pulse.
- Contention: `req`=4'b1111 held constant. Expect grant order 0,1,2,3,0, with each `gnt` exactly one-hot.
- NACK: master returns `mst_nack`=1 for address 0x11. Expect `err`=1 during `done`, and the next arbitration unaffected.
- Timeout (macro on, `TIMEOUT_CYC`=8): withhold `mst_done`. Expect `mst_abort` 8 cycles into WAIT_DONE, then `done` with `err`=1.
- Reset in WAIT_DONE: `rst_n` pulsed low. Expect `gnt`/`done` at 0 immediately, and after release the next grant goes to requester 0.
